// File: rtl/xgmii_pkg.sv
// Shared XGMII control codes, FSM state type and saturating-add helper
// for the receive monitor.
package xgmii_pkg;

  localparam logic [7:0] IDLE  = 8'h07;
  localparam logic [7:0] START = 8'hFB;
  localparam logic [7:0] TERM  = 8'hFD;
  localparam logic [7:0] ERROR = 8'hFE;
  localparam logic [7:0] PRE   = 8'h55;
  localparam logic [7:0] SFD   = 8'hD5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } rx_state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? '1 : s[15:0];
  endfunction

endpackage

// File: rtl/xgmii_word_decode.sv
// Combinational per-word classifier: start/terminate detection, error and
// stray-control flags ahead of the terminate, idle check after it.
module xgmii_word_decode
  import xgmii_pkg::*;
(
  input  logic [63:0] rxd,
  input  logic [7:0]  rxc,
  output logic        start_lane0,
  output logic        start_other,
  output logic        term_valid,
  output logic [2:0]  term_lane,
  output logic        err_present,
  output logic        bad_ctrl,
  output logic        tail_idle_ok
);

  logic [7:0] w_lane;

  always_comb begin
    start_lane0  = rxc[0] && (rxd[7:0] == START);
    start_other  = 1'b0;
    term_valid   = 1'b0;
    term_lane    = '0;
    err_present  = 1'b0;
    bad_ctrl     = 1'b0;
    tail_idle_ok = 1'b1;
    w_lane       = '0;
    // Lanes before the first terminate are payload; lanes after it must be idle.
    for (int unsigned n = 0; n < 8; n++) begin
      w_lane = rxd[8*n +: 8];
      if (rxc[n]) begin
        if (n != 0 && w_lane == START)
          start_other = 1'b1;
        if (term_valid) begin
          if (w_lane != IDLE)
            tail_idle_ok = 1'b0;
        end else if (w_lane == TERM) begin
          term_valid = 1'b1;
          term_lane  = n[2:0];
        end else if (w_lane == ERROR) begin
          err_present = 1'b1;
        end else if (!(n == 0 && w_lane == START)) begin
          bad_ctrl = 1'b1;
        end
      end else if (term_valid) begin
        tail_idle_ok = 1'b0;
      end
    end
  end

endmodule

// File: rtl/xgmii_rx_monitor.sv
// XGMII receive frame monitor: framing FSM, length/validity checks and
// saturating statistics. Optional start-word preamble check: XGMII_RX_MON_PREAMBLE_CHECK_EN.
module xgmii_rx_monitor
  import xgmii_pkg::*;
#(
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MAX_FRAME_LEN = 1518
) (
  input  logic        rx_clk,
  input  logic        rx_rst,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic        clr_stats,
  output logic        in_frame,
  output logic        frame_done,
  output logic        frame_bad,
  output logic [15:0] frame_len,
  output logic [31:0] good_count,
  output logic [31:0] bad_count,
  output logic [47:0] byte_count,
  output logic        framing_err
);

  logic       w_start_lane0, w_start_other, w_term_valid;
  logic [2:0] w_term_lane;
  logic       w_err_present, w_bad_ctrl, w_tail_idle_ok;

  xgmii_word_decode u_decode (
    .rxd          (xgmii_rxd),
    .rxc          (xgmii_rxc),
    .start_lane0  (w_start_lane0),
    .start_other  (w_start_other),
    .term_valid   (w_term_valid),
    .term_lane    (w_term_lane),
    .err_present  (w_err_present),
    .bad_ctrl     (w_bad_ctrl),
    .tail_idle_ok (w_tail_idle_ok)
  );

  rx_state_t   r_state, w_state_nxt;
  logic [15:0] r_len, w_len_nxt, w_term_len, w_end_len;
  logic        r_acc_bad, w_acc_bad_nxt;
  logic        w_end, w_end_bad, w_ferr, w_pre_bad;
  logic        r_frame_done, r_frame_bad, r_framing_err;
  logic [15:0] r_frame_len;
  logic [31:0] r_good, r_bad;
  logic [47:0] r_bytes;
  logic [48:0] w_byte_sum;

`ifdef XGMII_RX_MON_PREAMBLE_CHECK_EN
  assign w_pre_bad = !((xgmii_rxc[7:1] == 7'd0) && (xgmii_rxd[63:8] == {SFD, {6{PRE}}}));
`else
  assign w_pre_bad = 1'b0;
`endif

  assign w_term_len = sat_add16(r_len, {13'd0, w_term_lane});

  always_comb begin
    w_state_nxt   = r_state;
    w_len_nxt     = r_len;
    w_acc_bad_nxt = r_acc_bad;
    w_end         = 1'b0;
    w_end_bad     = 1'b0;
    w_end_len     = r_len;
    w_ferr        = w_start_other;
    case (r_state)
      ST_IDLE: begin
        if (w_start_lane0) begin
          w_state_nxt   = ST_FRAME;
          w_len_nxt     = '0;
          w_acc_bad_nxt = w_pre_bad;
        end else if (w_term_valid) begin
          w_ferr = 1'b1;
        end
      end
      ST_FRAME: begin
        if (w_start_lane0) begin
          // Restart: close the current frame as bad and open the next one.
          w_end         = 1'b1;
          w_end_bad     = 1'b1;
          w_len_nxt     = '0;
          w_acc_bad_nxt = w_pre_bad;
        end else if (w_term_valid) begin
          w_end       = 1'b1;
          w_end_len   = w_term_len;
          w_end_bad   = r_acc_bad || w_err_present || w_bad_ctrl || !w_tail_idle_ok
                        || ({16'd0, w_term_len} < MIN_FRAME_LEN)
                        || ({16'd0, w_term_len} > MAX_FRAME_LEN);
          w_state_nxt = ST_IDLE;
        end else begin
          w_len_nxt     = sat_add16(r_len, 16'd8);
          w_acc_bad_nxt = r_acc_bad || w_err_present || w_bad_ctrl;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      r_state       <= ST_IDLE;
      r_len         <= '0;
      r_acc_bad     <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_bad   <= 1'b0;
      r_frame_len   <= '0;
      r_framing_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_len         <= w_len_nxt;
      r_acc_bad     <= w_acc_bad_nxt;
      r_frame_done  <= w_end;
      r_framing_err <= w_ferr;
      if (w_end) begin
        r_frame_bad <= w_end_bad;
        r_frame_len <= w_end_len;
      end
    end
  end

  assign w_byte_sum = {1'b0, r_bytes} + {33'd0, w_end_len};

  always_ff @(posedge rx_clk) begin
    if (rx_rst || clr_stats) begin
      r_good  <= '0;
      r_bad   <= '0;
      r_bytes <= '0;
    end else if (w_end) begin
      if (w_end_bad) begin
        if (r_bad != '1)
          r_bad <= r_bad + 32'd1;
      end else begin
        if (r_good != '1)
          r_good <= r_good + 32'd1;
        r_bytes <= w_byte_sum[48] ? '1 : w_byte_sum[47:0];
      end
    end
  end

  assign in_frame    = (r_state == ST_FRAME);
  assign frame_done  = r_frame_done;
  assign frame_bad   = r_frame_bad;
  assign frame_len   = r_frame_len;
  assign good_count  = r_good;
  assign bad_count   = r_bad;
  assign byte_count  = r_bytes;
  assign framing_err = r_framing_err;

endmodule

// File: tb/tb_xgmii_rx_monitor.sv
// Scoreboard bench for xgmii_rx_monitor: expected frame results are queued
// as frames are driven and popped when frame_done fires.
module tb_xgmii_rx_monitor;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic        clr_stats;
  logic        in_frame, frame_done, frame_bad, framing_err;
  logic [15:0] frame_len;
  logic [31:0] good_count, bad_count;
  logic [47:0] byte_count;

  xgmii_rx_monitor #(.MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518)) dut (
    .rx_clk      (rx_clk),
    .rx_rst      (rx_rst),
    .xgmii_rxd   (xgmii_rxd),
    .xgmii_rxc   (xgmii_rxc),
    .clr_stats   (clr_stats),
    .in_frame    (in_frame),
    .frame_done  (frame_done),
    .frame_bad   (frame_bad),
    .frame_len   (frame_len),
    .good_count  (good_count),
    .bad_count   (bad_count),
    .byte_count  (byte_count),
    .framing_err (framing_err)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct packed {
    logic        bad;
    logic [15:0] len;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     n_ferr   = 0;
  int     m_ferr   = 0;
  int     m_good   = 0;
  int     m_bad    = 0;
  longint m_bytes  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge rx_clk) begin
    exp_t e;
    if (framing_err)
      n_ferr++;
    if (frame_done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", frame_done, 0);
      end else begin
        e = sb.pop_front();
        check_eq("frame_bad", frame_bad, e.bad);
        check_eq("frame_len", frame_len, e.len);
      end
    end
  end

  task automatic word(input logic [63:0] d, input logic [7:0] c);
    @(negedge rx_clk);
    xgmii_rxd = d;
    xgmii_rxc = c;
  endtask

  task automatic idle_w();
    word({8{8'h07}}, 8'hFF);
  endtask

  task automatic data_w();
    word({$urandom(), $urandom()}, 8'h00);
  endtask

  task automatic start_w(input logic [7:0] pre7);
    word({pre7, {6{8'h55}}, 8'hFB}, 8'h01);
  endtask

  task automatic term_w(input int k);
    logic [63:0] d;
    d = {$urandom(), $urandom()};
    for (int n = 0; n < 8; n++) begin
      if (n == k)     d[8*n +: 8] = 8'hFD;
      else if (n > k) d[8*n +: 8] = 8'h07;
    end
    word(d, 8'hFF << k);
  endtask

  task automatic expect_frame(input logic bad, input int len);
    exp_t e;
    e.bad = bad;
    e.len = 16'(len);
    sb.push_back(e);
    if (bad) m_bad++;
    else begin
      m_good++;
      m_bytes += len;
    end
  endtask

  task automatic send_frame(input int ndata, input int k, input logic [7:0] pre7);
    int   len;
    logic bad;
    len = 8 * ndata + k;
    bad = (len < 64) || (len > 1518);
`ifdef XGMII_RX_MON_PREAMBLE_CHECK_EN
    bad = bad || (pre7 != 8'hD5);
`endif
    expect_frame(bad, len);
    start_w(pre7);
    repeat (ndata) data_w();
    term_w(k);
  endtask

  task automatic chk_counters(input string tag);
    idle_w();
    idle_w();
    check_eq({tag, "_good"}, good_count, m_good);
    check_eq({tag, "_bad"}, bad_count, m_bad);
    check_eq({tag, "_bytes"}, byte_count, m_bytes);
    check_eq({tag, "_ferr"}, n_ferr, m_ferr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_rst    = 1'b1;
    clr_stats = 1'b0;
    xgmii_rxd = {8{8'h07}};
    xgmii_rxc = 8'hFF;
    repeat (3) @(negedge rx_clk);
    check_eq("rst_in_frame", in_frame, 0);
    check_eq("rst_done", frame_done, 0);
    check_eq("rst_good", good_count, 0);
    check_eq("rst_bad", bad_count, 0);
    check_eq("rst_bytes", byte_count, 0);
    check_eq("rst_ferr", framing_err, 0);
    rx_rst = 1'b0;

    send_frame(7, 4, 8'hD5);
    chk_counters("runt60");
    send_frame(8, 0, 8'hD5);
    chk_counters("min64");

    expect_frame(1'b1, 64);
    start_w(8'hD5);
    data_w();
    data_w();
    word({32'h1234_5678, 8'hFE, 24'hABCDEF}, 8'h08);
    repeat (5) data_w();
    term_w(0);
    chk_counters("err_fe");

    expect_frame(1'b1, 66);
    m_ferr++;
    start_w(8'hD5);
    repeat (8) data_w();
    word({8'h07, 8'h07, 8'hFB, 8'h07, 8'h07, 8'hFD, 16'h1234}, 8'hFC);
    chk_counters("term_fb");

    expect_frame(1'b1, 24);
    expect_frame(1'b0, 64);
    start_w(8'hD5);
    repeat (3) data_w();
    start_w(8'hD5);
    data_w();
    check_eq("restart_in_frame", in_frame, 1);
    repeat (7) data_w();
    term_w(0);
    chk_counters("restart");

    send_frame(7, 7, 8'hD5);
    send_frame(189, 6, 8'hD5);
    send_frame(189, 7, 8'hD5);
    send_frame(20, 3, 8'hD5);
    chk_counters("bounds");

    m_ferr++;
    term_w(3);
    chk_counters("idle_term");

    expect_frame(1'b0, 64);
    start_w(8'hD5);
    repeat (8) data_w();
    term_w(0);
    clr_stats = 1'b1;
    idle_w();
    clr_stats = 1'b0;
    m_good  = 0;
    m_bad   = 0;
    m_bytes = 0;
    check_eq("clr_good", good_count, 0);
    check_eq("clr_bytes", byte_count, 0);

    send_frame(8, 1, 8'hD5);
    chk_counters("post_clr");

    start_w(8'hD5);
    repeat (3) data_w();
    rx_rst = 1'b1;
    @(negedge rx_clk);
    m_good  = 0;
    m_bad   = 0;
    m_bytes = 0;
    check_eq("rst_mid_in_frame", in_frame, 0);
    check_eq("rst_mid_good", good_count, 0);
    expect_frame(1'b0, 64);
    xgmii_rxd = {8'hD5, {6{8'h55}}, 8'hFB};
    xgmii_rxc = 8'h01;
    rx_rst    = 1'b0;
    repeat (8) data_w();
    term_w(0);
    chk_counters("rst_restart");

    send_frame(8, 0, 8'hD4);
    chk_counters("preamble");

    repeat (4) idle_w();
    check_eq("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
